// File: rtl/cordic_sqrt_prenorm.sv
// cordic_sqrt_prenorm: range-reduces an unsigned operand to m*4^exp, m in [0.25,1),
// and emits the hyperbolic-vectoring seed x_0=m+0.25, y_0=m-0.25, z_0=0.
// Ports: clk, rst (async, active-high); in_valid/in_ready/din operand handshake;
//        out_valid/out_ready seed handshake; x_0, y_0, z_0 (FW signed), exp, zero.
module cordic_sqrt_prenorm #(
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14,
  parameter int IN_WIDTH  = 32,
  parameter int IN_FRAC   = 16,
  parameter int EXP_WIDTH = 6,
  localparam int FW = SYM_WIDTH + INT_WIDTH + DEC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_WIDTH-1:0]         din,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FW-1:0]               x_0,
  output logic [FW-1:0]               y_0,
  output logic [FW-1:0]               z_0,
  output logic signed [EXP_WIDTH-1:0] exp,
  output logic                        zero
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    OUT
  } state_t;

  localparam logic [FW-1:0] QTR = FW'(1) << (DEC_WIDTH - 2);
  localparam logic [EXP_WIDTH-1:0] EONE = EXP_WIDTH'(1);

  state_t state, nstate;

  logic [IN_WIDTH-1:0]  mreg;
  logic [EXP_WIDTH-1:0] ereg;
  logic                 mzero;
  logic                 hi;
  logic                 lo_empty;
  logic [FW-1:0]        m_fix;

  assign mzero    = (mreg == '0);
  // Any integer bit set means m >= 1: shift right by one power of four.
  assign hi       = |mreg[IN_WIDTH-1:IN_FRAC];
  // Top two fraction bits clear means m < 0.25: shift left.
  assign lo_empty = ~|mreg[IN_FRAC-1 -: 2];
  assign m_fix    = {{(FW-DEC_WIDTH){1'b0}},
                     mreg[IN_FRAC-1 -: DEC_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = NORM;
      end
      NORM: begin
        if (mzero || (!hi && !lo_empty)) nstate = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mreg <= '0;
      ereg <= '0;
      x_0  <= '0;
      y_0  <= '0;
      z_0  <= '0;
      exp  <= '0;
      zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mreg <= din;
            ereg <= '0;
          end
        end
        NORM: begin
          if (mzero) begin
            zero <= 1'b1;
            x_0  <= '0;
            y_0  <= '0;
            z_0  <= '0;
            exp  <= '0;
          end else if (hi) begin
            mreg <= mreg >> 2;
            ereg <= ereg + EONE;
          end else if (lo_empty) begin
            mreg <= mreg << 2;
            ereg <= ereg - EONE;
          end else begin
            x_0  <= m_fix + QTR;
            y_0  <= m_fix - QTR;
            z_0  <= '0;
            exp  <= ereg;
            zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
